// File: rtl/execute_stage_if.sv
// Decode/execute/memory bus for the execute stage: operands in, pipeline copies,
// combinational ALU result and registered execute/memory results out.
interface execute_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] aluOp_in;
    logic [WIDTH-1:0] srcA_in;
    logic [WIDTH-1:0] srcB_in;
    logic [WIDTH-1:0] aluOp_out;
    logic [WIDTH-1:0] srcA_out;
    logic [WIDTH-1:0] srcB_out;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH-1:0] ALUresult_out;
    logic [3:0]       flags_out;

    modport master (
        output aluOp_in, srcA_in, srcB_in,
        input  aluOp_out, srcA_out, srcB_out, result, flags, ALUresult_out, flags_out
    );

    modport slave (
        input  aluOp_in, srcA_in, srcB_in,
        output aluOp_out, srcA_out, srcB_out, result, flags, ALUresult_out, flags_out
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: decode/execute register, combinational 16-op ALU with {N,Z,C,V},
// and execute/memory register for result and flags.
module execute_stage #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    execute_stage_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;
    localparam logic [3:0] OP_PASA = 4'd13;
    localparam logic [3:0] OP_PASB = 4'd14;

    logic [WIDTH-1:0]        alu_op_p0;
    logic [WIDTH-1:0]        src_a_p0;
    logic [WIDTH-1:0]        src_b_p0;
    logic [WIDTH-1:0]        result_p1;
    logic [3:0]              flags_p1;

    logic [3:0]              op;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SH_W-1:0]         shamt;
    logic [WIDTH:0]          sum_w;
    logic [WIDTH:0]          diff_w;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c;
    logic                    alu_v;
    logic [3:0]              alu_flags;

    // decode/execute boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op_p0 <= '0;
            src_a_p0  <= '0;
            src_b_p0  <= '0;
        end else begin
            alu_op_p0 <= bus.aluOp_in;
            src_a_p0  <= bus.srcA_in;
            src_b_p0  <= bus.srcB_in;
        end
    end

    assign op     = alu_op_p0[3:0];
    assign a_s    = $signed(src_a_p0);
    assign b_s    = $signed(src_b_p0);
    assign shamt  = src_b_p0[SH_W-1:0];
    assign sum_w  = {1'b0, src_a_p0} + {1'b0, src_b_p0};
    assign diff_w = {1'b0, src_a_p0} - {1'b0, src_b_p0};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (src_a_p0[WIDTH-1] == src_b_p0[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != src_a_p0[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                // diff_w MSB is the borrow; carry means no borrow
                alu_c   = ~diff_w[WIDTH];
                alu_v   = (src_a_p0[WIDTH-1] != src_b_p0[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != src_a_p0[WIDTH-1]);
            end
            OP_AND:  alu_res = src_a_p0 & src_b_p0;
            OP_OR:   alu_res = src_a_p0 | src_b_p0;
            OP_XOR:  alu_res = src_a_p0 ^ src_b_p0;
            OP_NOR:  alu_res = ~(src_a_p0 | src_b_p0);
            OP_NOT:  alu_res = ~src_a_p0;
            OP_SLL:  alu_res = src_a_p0 << shamt;
            OP_SRL:  alu_res = src_a_p0 >> shamt;
            OP_SRA:  alu_res = $unsigned(a_s >>> shamt);
            OP_MUL:  alu_res = src_a_p0 * src_b_p0;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a_p0 < src_b_p0)};
            OP_PASA: alu_res = src_a_p0;
            OP_PASB: alu_res = src_b_p0;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    // execute/memory boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_p1 <= '0;
            flags_p1  <= '0;
        end else begin
            result_p1 <= alu_res;
            flags_p1  <= alu_flags;
        end
    end

    assign bus.aluOp_out     = alu_op_p0;
    assign bus.srcA_out      = src_a_p0;
    assign bus.srcB_out      = src_b_p0;
    assign bus.result        = alu_res;
    assign bus.flags         = alu_flags;
    assign bus.ALUresult_out = result_p1;
    assign bus.flags_out     = flags_p1;
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: golden ALU model, directed vectors,
// back-to-back random ops and asynchronous mid-stream reset.
module tb_execute_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [19:0] scoreboard[$];

    execute_stage_if #(.WIDTH(16)) bus ();

    execute_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Returns {N,Z,C,V, result[15:0]}
    function automatic logic [19:0] golden(input logic [15:0] opw, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [3:0]  op;
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        v;
        int          sh;
        int          sa;
        int          sbv;
        longint      p;
        op  = opw[3:0];
        c   = 1'b0;
        v   = 1'b0;
        r   = 16'h0;
        sh  = int'(b[3:0]);
        sa  = a[15] ? int'(a) - 65536 : int'(a);
        sbv = b[15] ? int'(b) - 65536 : int'(b);
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = ~a;
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  r = (a >> sh) | (a[15] ? ~(16'hFFFF >> sh) : 16'h0000);
            4'd10: begin
                p = longint'(a) * longint'(b);
                r = p[15:0];
            end
            4'd11: r = (sa < sbv) ? 16'd1 : 16'd0;
            4'd12: r = (a < b) ? 16'd1 : 16'd0;
            4'd13: r = a;
            4'd14: r = b;
            default: r = 16'h0;
        endcase
        return {r[15], (r == 16'h0), c, v, r};
    endfunction

    task automatic step(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] g;
        logic [19:0] e;
        bus.aluOp_in = op;
        bus.srcA_in  = a;
        bus.srcB_in  = b;
        g = golden(op, a, b);
        @(posedge clk);
        #1;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            chk("alu_result_out", bus.ALUresult_out, e[15:0]);
            chk("flags_out", bus.flags_out, e[19:16]);
        end
        chk("result", bus.result, g[15:0]);
        chk("flags", bus.flags, g[19:16]);
        chk("alu_op_out", bus.aluOp_out, op);
        chk("src_a_out", bus.srcA_out, a);
        chk("src_b_out", bus.srcB_out, b);
        scoreboard.push_back(g);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.aluOp_in = 16'h0000;
        bus.srcA_in  = 16'h0000;
        bus.srcB_in  = 16'h0000;
        #2;
        chk("rst_alu_op_out", bus.aluOp_out, 16'h0);
        chk("rst_alu_result_out", bus.ALUresult_out, 16'h0);
        chk("rst_flags_out", bus.flags_out, 4'h0);
        chk("rst_result", bus.result, 16'h0);
        chk("rst_flags", bus.flags, 4'b0100);
        #1 reset = 1'b0;
        // first edge after reset captures the reset-state ALU output
        scoreboard.push_back({4'b0100, 16'h0000});

        step(16'h0000, 16'h0003, 16'h0004);
        chk("add_basic", bus.result, 16'h0007);
        step(16'h0000, 16'h7FFF, 16'h0001);
        chk("add_ovf_res", bus.result, 16'h8000);
        chk("add_ovf_flags", bus.flags, 4'b1001);
        chk("add_basic_reg", bus.ALUresult_out, 16'h0007);
        chk("add_basic_flags_reg", bus.flags_out, 4'b0000);
        step(16'h0000, 16'hFFFF, 16'h0001);
        chk("add_carry_flags", bus.flags, 4'b0110);
        step(16'h0001, 16'h0005, 16'h0005);
        chk("sub_eq_flags", bus.flags, 4'b0110);
        step(16'h000B, 16'hFFFF, 16'h0001);
        chk("slt", bus.result, 16'h0001);
        step(16'h000C, 16'hFFFF, 16'h0001);
        chk("sltu", bus.result, 16'h0000);
        step(16'h0007, 16'h8001, 16'h0004);
        chk("sll4", bus.result, 16'h0010);
        step(16'h0008, 16'h8001, 16'h0004);
        chk("srl4", bus.result, 16'h0800);
        step(16'h0009, 16'h8001, 16'h0004);
        chk("sra4", bus.result, 16'hF800);
        step(16'h0007, 16'h8001, 16'h0010);
        chk("sll16", bus.result, 16'h8001);
        step(16'h0008, 16'h8001, 16'h0010);
        chk("srl16", bus.result, 16'h8001);
        step(16'h0009, 16'h8001, 16'h0010);
        chk("sra16", bus.result, 16'h8001);
        step(16'hABC0, 16'h1234, 16'h1111);
        chk("op_upper_bits", bus.result, 16'h2345);

        for (int i = 0; i < 16; i++) begin
            step(16'(i), 16'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            step(16'($urandom), 16'($urandom), 16'($urandom));
        end

        // asynchronous reset between edges with data in flight
        step(16'h0000, 16'h1234, 16'h4321);
        #3 reset = 1'b1;
        #1;
        chk("mid_alu_op_out", bus.aluOp_out, 16'h0);
        chk("mid_src_a_out", bus.srcA_out, 16'h0);
        chk("mid_src_b_out", bus.srcB_out, 16'h0);
        chk("mid_alu_result_out", bus.ALUresult_out, 16'h0);
        chk("mid_flags_out", bus.flags_out, 4'h0);
        chk("mid_result", bus.result, 16'h0);
        chk("mid_flags", bus.flags, 4'b0100);
        #1 reset = 1'b0;
        scoreboard.delete();
        scoreboard.push_back({4'b0100, 16'h0000});

        step(16'h0001, 16'h0003, 16'h0005);
        step(16'h000A, 16'h0123, 16'h0456);
        step(16'h0005, 16'h00F0, 16'h0F00);
        step(16'h000F, 16'hFFFF, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
